// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: walks operands MSB first, one bit per clock,
// reporting less/greater/equal and how many bit positions were examined.

module serial_comparator_bitcmp (
  input  logic i_a,
  input  logic i_b,
  input  logic i_inv,
  output logic o_lt,
  output logic o_gt
);
  logic w_a_only;
  logic w_b_only;

  assign w_a_only = i_a & ~i_b;
  assign w_b_only = ~i_a & i_b;

  // Sign bit of a two's-complement operand carries negative weight, so its sense flips.
  assign o_lt = i_inv ? w_a_only : w_b_only;
  assign o_gt = i_inv ? w_b_only : w_a_only;
endmodule

module serial_comparator #(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic                   is_signed,
  output logic                   busy,
  output logic                   done,
  output logic                   L,
  output logic                   G,
  output logic                   E,
  output logic [$clog2(W+1)-1:0] nbits
);
  localparam int IW = $clog2(W);
  localparam int NW = $clog2(W+1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sgn;
  logic [IW-1:0]   r_idx;
  logic            r_lt;
  logic            r_gt;
  logic            r_done;
  logic            r_L;
  logic            r_G;
  logic            r_E;
  logic [NW-1:0]   r_nbits;

  logic            w_accept;
  logic            w_finish;
  logic            w_inv;
  logic            w_lt;
  logic            w_gt;
  logic            w_new;
  logic            w_last;
  logic            w_lt_fin;
  logic            w_gt_fin;
  logic [NW-1:0]   w_nbits;

  assign w_inv  = r_sgn & (r_idx == IW'(W-1));
  assign w_last = (r_idx == '0);

  serial_comparator_bitcmp u_bitcmp (
    .i_a  (r_a[r_idx]),
    .i_b  (r_b[r_idx]),
    .i_inv(w_inv),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  // Only the first differing bit counts; once decided, later bits are ignored.
  assign w_new    = (w_lt | w_gt) & ~(r_lt | r_gt);
  assign w_lt_fin = r_lt | (w_new & w_lt);
  assign w_gt_fin = r_gt | (w_new & w_gt);
  assign w_nbits  = EARLY_EXIT ? (NW'(W) - NW'(r_idx)) : NW'(W);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last || (EARLY_EXIT && w_new)) begin
          w_finish   = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_idx   <= '0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
      r_done  <= 1'b0;
      r_L     <= 1'b0;
      r_G     <= 1'b0;
      r_E     <= 1'b0;
      r_nbits <= '0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_sgn <= is_signed;
        r_idx <= IW'(W-1);
        r_lt  <= 1'b0;
        r_gt  <= 1'b0;
        r_L   <= 1'b0;
        r_G   <= 1'b0;
        r_E   <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_lt  <= w_lt_fin;
        r_gt  <= w_gt_fin;
        r_idx <= r_idx - IW'(1);
        // Published results stay frozen until the next accepted start.
        if (w_finish) begin
          r_L     <= w_lt_fin;
          r_G     <= w_gt_fin;
          r_E     <= ~(w_lt_fin | w_gt_fin);
          r_nbits <= w_nbits;
        end
      end
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;
  assign L     = r_L;
  assign G     = r_G;
  assign E     = r_E;
  assign nbits = r_nbits;
endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: early-exit and full-scan instances,
// latency, signed MSB handling, busy-start rejection, reset abort.

module tb_serial_comparator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start0 = 1'b0;
  logic [7:0] a = '0, b = '0, a0 = '0, b0 = '0;
  logic       sg = 1'b0, sg0 = 1'b0;
  logic       busy, done, L, G, E;
  logic       busy0, done0, L0, G0, E0;
  logic [3:0] nbits, nbits0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_comparator #(.W(8), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(sg),
    .busy(busy), .done(done), .L(L), .G(G), .E(E), .nbits(nbits)
  );

  serial_comparator #(.W(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .is_signed(sg0),
    .busy(busy0), .done(done0), .L(L0), .G(G0), .E(E0), .nbits(nbits0)
  );

  // Stimulus only: pulses start on the early-exit DUT and measures latency
  // in edges from acceptance to the edge that samples done (-1 on timeout).
  task automatic run_cmp(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                         output int lat);
    int  m;
    bit  found;
    @(negedge clk); a = ia; b = ib; sg = is; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat = -1; m = 0; found = 1'b0;
    while (!found && m < 40) begin
      @(posedge clk); m++;
      @(negedge clk);
      if (done) begin found = 1'b1; lat = m + 1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if ({L, G, E} !== 3'b000) begin bad++; $display("FAIL reset_lge: got %b want 000", {L, G, E}); end
    total++; if (nbits !== 4'd0) begin bad++; $display("FAIL reset_nbits: got %0d want 0", nbits); end
    total++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin bad++; $display("FAIL reset_dut0: got busy=%b done=%b want 0 0", busy0, done0); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_lt;
    int lat;
    run_cmp(8'd42, 8'd88, 1'b0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL lt_latency: got %0d want 3", lat); end
    total++; if ({L, G, E} !== 3'b100) begin bad++; $display("FAIL lt_lge: got %b want 100", {L, G, E}); end
    total++; if (nbits !== 4'd2) begin bad++; $display("FAIL lt_nbits: got %0d want 2", nbits); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lt_busy_at_done: got %b want 0", busy); end
  endtask

  task automatic test_signed_msb;
    int lat;
    run_cmp(8'd200, 8'd100, 1'b0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL uns_msb_latency: got %0d want 2", lat); end
    total++; if ({L, G, E} !== 3'b010) begin bad++; $display("FAIL uns_msb_lge: got %b want 010", {L, G, E}); end
    total++; if (nbits !== 4'd1) begin bad++; $display("FAIL uns_msb_nbits: got %0d want 1", nbits); end
    run_cmp(8'd200, 8'd100, 1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sgn_msb_latency: got %0d want 2", lat); end
    total++; if ({L, G, E} !== 3'b100) begin bad++; $display("FAIL sgn_msb_lge: got %b want 100", {L, G, E}); end
    total++; if (nbits !== 4'd1) begin bad++; $display("FAIL sgn_msb_nbits: got %0d want 1", nbits); end
  endtask

  task automatic test_equal_and_hold;
    int lat;
    run_cmp(8'd133, 8'd133, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL eq_latency: got %0d want 9", lat); end
    total++; if ({L, G, E} !== 3'b001) begin bad++; $display("FAIL eq_lge: got %b want 001", {L, G, E}); end
    total++; if (nbits !== 4'd8) begin bad++; $display("FAIL eq_nbits: got %0d want 8", nbits); end
    run_cmp(8'd150, 8'd128, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL gt4_latency: got %0d want 5", lat); end
    total++; if ({L, G, E} !== 3'b010) begin bad++; $display("FAIL gt4_lge: got %b want 010", {L, G, E}); end
    total++; if (nbits !== 4'd4) begin bad++; $display("FAIL gt4_nbits: got %0d want 4", nbits); end
    a = 8'd0; b = 8'd255;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_done: got %b want 0", done); end
    total++; if ({L, G, E} !== 3'b010 || nbits !== 4'd4) begin bad++; $display("FAIL hold_result: got lge=%b nbits=%0d want 010 4", {L, G, E}, nbits); end
  endtask

  task automatic test_full_scan;
    int  m;
    int  lat;
    bit  found;
    logic [7:0] va [2] = '{8'd42, 8'd200};
    logic [7:0] vb [2] = '{8'd88, 8'd100};
    logic       vs [2] = '{1'b0, 1'b1};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk); a0 = va[v]; b0 = vb[v]; sg0 = vs[v]; start0 = 1'b1;
      @(posedge clk);
      @(negedge clk); start0 = 1'b0;
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL full_busy%0d: got %b want 1", v, busy0); end
      lat = -1; m = 0; found = 1'b0;
      while (!found && m < 40) begin
        @(posedge clk); m++;
        @(negedge clk);
        if (done0) begin found = 1'b1; lat = m + 1; end
      end
      total++; if (lat !== 9) begin bad++; $display("FAIL full_latency%0d: got %0d want 9", v, lat); end
      total++; if ({L0, G0, E0} !== 3'b100) begin bad++; $display("FAIL full_lge%0d: got %b want 100", v, {L0, G0, E0}); end
      total++; if (nbits0 !== 4'd8) begin bad++; $display("FAIL full_nbits%0d: got %0d want 8", v, nbits0); end
    end
  endtask

  task automatic test_back_to_back;
    int  m;
    int  lat;
    bit  found;
    @(negedge clk); a = 8'd42; b = 8'd88; sg = 1'b0; start = 1'b1;
    @(posedge clk);
    // Start held high with other operands while busy must be ignored.
    @(negedge clk); a = 8'd200; b = 8'd100; start = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
    @(posedge clk);
    @(negedge clk); start = 1'b0; a = 8'd255; b = 8'd0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_early_done: got %b want 0", done); end
    @(posedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1: got %b want 1", done); end
    total++; if ({L, G, E} !== 3'b100 || nbits !== 4'd2) begin bad++; $display("FAIL b2b_result1: got lge=%b nbits=%0d want 100 2", {L, G, E}, nbits); end
    a = 8'd150; b = 8'd128; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got done=%b busy=%b want 0 1", done, busy); end
    lat = -1; m = 0; found = 1'b0;
    while (!found && m < 40) begin
      @(posedge clk); m++;
      @(negedge clk);
      if (done) begin found = 1'b1; lat = m + 1; end
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL b2b_latency2: got %0d want 5", lat); end
    total++; if ({L, G, E} !== 3'b010 || nbits !== 4'd4) begin bad++; $display("FAIL b2b_result2: got lge=%b nbits=%0d want 010 4", {L, G, E}, nbits); end
  endtask

  task automatic test_reset_abort;
    int dcnt;
    int lat;
    @(negedge clk); a = 8'd133; b = 8'd133; sg = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    total++; if ({L, G, E} !== 3'b000 || nbits !== 4'd0) begin bad++; $display("FAIL abort_outputs: got lge=%b nbits=%0d want 000 0", {L, G, E}, nbits); end
    dcnt = 0;
    repeat (10) begin @(negedge clk); if (done) dcnt++; end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
    run_cmp(8'd42, 8'd88, 1'b0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL abort_after_latency: got %0d want 3", lat); end
    total++; if ({L, G, E} !== 3'b100 || nbits !== 4'd2) begin bad++; $display("FAIL abort_after_result: got lge=%b nbits=%0d want 100 2", {L, G, E}, nbits); end
  endtask

  initial begin
    test_reset();
    test_unsigned_lt();
    test_signed_msb();
    test_equal_and_hold();
    test_full_scan();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
